// File: rtl/trace_fifo_mc.sv
// Multi-channel trace buffer: round-robin merge of NUM_CH producers into one circular store, FWFT output.
// Latency: a record accepted in cycle N is visible on the output in cycle N+1.
// Backpressure: OVERWRITE=0 stalls producers when full (unless popping); OVERWRITE=1 drops the oldest record.
// Optional statistics outputs (drop_cnt, high_water) exist when TRACE_FIFO_MC_STATS_EN is defined.
module trace_fifo_mc #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int NUM_CH    = 2,
  parameter int OVERWRITE = 0
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic [NUM_CH-1:0]                          i_in_valid,
  input  logic [NUM_CH*DATA_W-1:0]                   i_in_data,
  output logic [NUM_CH-1:0]                          o_in_ready,
  output logic                                       o_out_valid,
  output logic [DATA_W-1:0]                          o_out_data,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] o_out_ch,
  input  logic                                       i_out_ready,
  output logic [$clog2(DEPTH+1)-1:0]                 o_count,
  output logic                                       o_full
`ifdef TRACE_FIFO_MC_STATS_EN
  ,
  output logic [15:0]                                o_drop_cnt,
  output logic [$clog2(DEPTH+1)-1:0]                 o_high_water
`endif
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] r_mem_dat [DEPTH];
  logic [CH_W-1:0]   r_mem_ch  [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CH_W-1:0]   r_rr_ptr;

  logic              w_gnt_vld;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [CH_W-1:0]   w_cand;
  logic [DATA_W-1:0] w_gnt_dat;
  logic              w_full;
  logic              w_pop;
  logic              w_elig;
  logic              w_push;
  logic              w_ovw;
  logic [CNT_W-1:0]  w_count_nxt;

  // Round-robin search over valid channels, starting at r_rr_ptr.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_cand = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
      if (!w_gnt_vld && i_in_valid[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_gnt_dat   = i_in_data[w_gnt_idx*DATA_W +: DATA_W];
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign o_out_valid = (r_count != '0);
  assign w_pop       = o_out_valid & i_out_ready;
  // A full buffer can still take a record when the head leaves in the same cycle.
  assign w_elig      = (OVERWRITE != 0) || !w_full || w_pop;
  assign w_push      = w_gnt_vld & w_elig & ~i_rst;
  // Overwrite-oldest: full, pushing, nobody popping -> head is discarded.
  assign w_ovw       = w_push & w_full & ~w_pop;

  // One-hot accept to the granted channel only.
  always_comb begin
    o_in_ready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      o_in_ready[c] = w_push && (w_gnt_idx == CH_W'(c));
    end
  end

  // Occupancy for next cycle; overwrite keeps the buffer at DEPTH.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop && !w_full) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Storage write; contents need no reset because count gates the output.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_dat[r_wr_ptr] <= w_gnt_dat;
      r_mem_ch[r_wr_ptr]  <= w_gnt_idx;
    end
  end

  // Pointer, occupancy and arbitration state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= (w_gnt_idx == CH_W'(NUM_CH-1)) ? '0 : w_gnt_idx + 1'b1;
      end
      if (w_pop || w_ovw) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
    end
  end

  // First-word fall-through head, forced to zero while empty.
  assign o_out_data = o_out_valid ? r_mem_dat[r_rd_ptr] : '0;
  assign o_out_ch   = o_out_valid ? r_mem_ch[r_rd_ptr]  : '0;
  assign o_count    = r_count;
  assign o_full     = w_full;

`ifdef TRACE_FIFO_MC_STATS_EN
  logic [15:0]      r_drop_cnt;
  logic [CNT_W-1:0] r_high_water;

  // Saturating drop counter and peak occupancy tracker.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drop_cnt   <= '0;
      r_high_water <= '0;
    end else begin
      if (w_ovw && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_count_nxt > r_high_water) begin
        r_high_water <= w_count_nxt;
      end
    end
  end

  assign o_drop_cnt   = r_drop_cnt;
  assign o_high_water = r_high_water;
`endif

endmodule

// File: tb/tb_trace_fifo_mc.sv
// Bench for trace_fifo_mc: one backpressure instance (DEPTH=16) and one overwrite instance (DEPTH=4).
// Scoreboard queues hold expected records in acceptance order; heads are compared each cycle.
// Inputs change on the falling edge, outputs are sampled 1 time unit later.
module tb_trace_fifo_mc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Backpressure instance signals
  logic        rst_m;
  logic [1:0]  m_vld;
  logic [63:0] m_dat;
  logic [1:0]  m_rdy;
  logic        m_ovld;
  logic [31:0] m_odat;
  logic        m_och;
  logic        m_ordy;
  logic [4:0]  m_cnt;
  logic        m_full;

  // Overwrite instance signals
  logic        rst_w;
  logic [1:0]  w_vld;
  logic [63:0] w_dat;
  logic [1:0]  w_rdy;
  logic        w_ovld;
  logic [31:0] w_odat;
  logic        w_och;
  logic        w_ordy;
  logic [2:0]  w_cnt;
  logic        w_full;

`ifdef TRACE_FIFO_MC_STATS_EN
  logic [15:0] m_drop, w_drop;
  logic [4:0]  m_hw;
  logic [2:0]  w_hw;
`endif

  trace_fifo_mc #(.DATA_W(32), .DEPTH(16), .NUM_CH(2), .OVERWRITE(0)) u_dut (
    .i_clk(clk), .i_rst(rst_m), .i_in_valid(m_vld), .i_in_data(m_dat), .o_in_ready(m_rdy),
    .o_out_valid(m_ovld), .o_out_data(m_odat), .o_out_ch(m_och), .i_out_ready(m_ordy),
    .o_count(m_cnt), .o_full(m_full)
`ifdef TRACE_FIFO_MC_STATS_EN
    , .o_drop_cnt(m_drop), .o_high_water(m_hw)
`endif
  );

  trace_fifo_mc #(.DATA_W(32), .DEPTH(4), .NUM_CH(2), .OVERWRITE(1)) u_ovw (
    .i_clk(clk), .i_rst(rst_w), .i_in_valid(w_vld), .i_in_data(w_dat), .o_in_ready(w_rdy),
    .o_out_valid(w_ovld), .o_out_data(w_odat), .o_out_ch(w_och), .i_out_ready(w_ordy),
    .o_count(w_cnt), .o_full(w_full)
`ifdef TRACE_FIFO_MC_STATS_EN
    , .o_drop_cnt(w_drop), .o_high_water(w_hw)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  logic [32:0] q_m [$];   // {ch, data}
  logic [31:0] q_w [$];
  int          m_rr = 0;
  int          w_drops = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle on the backpressure instance, with an independent reference model.
  task automatic cyc(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                     input logic ordy, input logic rst);
    int          g;
    logic        elig;
    logic [1:0]  exp_rdy;
    logic [31:0] dsel;
    @(negedge clk);
    rst_m  = rst;
    m_vld  = v;
    m_dat  = {d1, d0};
    m_ordy = ordy;
    #1;
    g = -1;
    for (int k = 0; k < 2; k++) begin
      int i;
      i = (m_rr + k) % 2;
      if (g < 0 && v[i]) g = i;
    end
    elig    = (q_m.size() < 16) || (q_m.size() != 0 && ordy);
    exp_rdy = (g >= 0 && elig && !rst) ? (2'b01 << g) : 2'b00;
    chk("count", m_cnt, q_m.size());
    chk("full", m_full, q_m.size() == 16);
    chk("out_valid", m_ovld, q_m.size() != 0);
    chk("out_data", m_odat, (q_m.size() != 0) ? q_m[0][31:0] : 32'h0);
    chk("out_ch", m_och, (q_m.size() != 0) ? q_m[0][32] : 1'b0);
    chk("in_ready", m_rdy, exp_rdy);
    if (rst) begin
      q_m.delete();
      m_rr = 0;
    end else begin
      if (q_m.size() != 0 && ordy) void'(q_m.pop_front());
      if (exp_rdy != 2'b00) begin
        dsel = (g == 0) ? d0 : d1;
        q_m.push_back({g[0], dsel});
        m_rr = (g + 1) % 2;
      end
    end
  endtask

  // One cycle on the overwrite instance, channel 0 only.
  task automatic cyc_w(input logic v, input logic [31:0] d, input logic ordy);
    @(negedge clk);
    rst_w  = 1'b0;
    w_vld  = {1'b0, v};
    w_dat  = {32'h0, d};
    w_ordy = ordy;
    #1;
    chk("ow_count", w_cnt, q_w.size());
    chk("ow_full", w_full, q_w.size() == 4);
    chk("ow_head", w_odat, (q_w.size() != 0) ? q_w[0] : 32'h0);
    chk("ow_in_ready", w_rdy, {1'b0, v});
    if (q_w.size() != 0 && ordy) void'(q_w.pop_front());
    else if (v && q_w.size() == 4) begin
      void'(q_w.pop_front());
      w_drops++;
    end
    if (v) q_w.push_back(d);
  endtask

  initial begin
    rst_m = 1'b1; m_vld = '0; m_dat = '0; m_ordy = 1'b0;
    rst_w = 1'b1; w_vld = '0; w_dat = '0; w_ordy = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, with producers asserting valid: nothing may be accepted.
    cyc(2'b11, 32'h1, 32'h2, 1'b1, 1'b1);

    // Single channel fill to full, then push attempt while full, then drain in order.
    for (int n = 0; n < 16; n++) cyc(2'b01, 32'(n), 32'h0, 1'b0, 1'b0);
    cyc(2'b01, 32'h10, 32'h0, 1'b0, 1'b0);
    for (int n = 0; n < 17; n++) cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);

    // Both channels valid every cycle, consumer always ready: alternating grants.
    for (int n = 0; n < 8; n++) cyc(2'b11, 32'hA0 + 32'(n), 32'hB0 + 32'(n), 1'b1, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);

    // Full plus simultaneous push/pop: accepted, occupancy held, 0x55 drains last.
    repeat (16) cyc(2'b01, 32'h100 + 32'(q_m.size()), 32'h0, 1'b0, 1'b0);
    cyc(2'b01, 32'h55, 32'h0, 1'b1, 1'b0);
    for (int n = 0; n < 17; n++) cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);

    // Pointer wrap: occupancy held at 3 over 40 push/pop pairs.
    for (int n = 0; n < 3; n++) cyc(2'b10, 32'h0, 32'hC00 + 32'(n), 1'b0, 1'b0);
    for (int n = 0; n < 40; n++) cyc(2'b10, 32'h0, 32'hD00 + 32'(n), 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset with 7 entries and pushes in flight, then first push after reset.
    for (int n = 0; n < 7; n++) cyc(2'b01, 32'hE0 + 32'(n), 32'h0, 1'b0, 1'b0);
    cyc(2'b11, 32'hEE, 32'hEF, 1'b1, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(2'b10, 32'h0, 32'h77, 1'b0, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);

    // Overwrite-oldest: push 1..6 into DEPTH=4, drain yields 3,4,5,6.
    for (int n = 1; n <= 6; n++) cyc_w(1'b1, 32'(n), 1'b0);
    for (int n = 0; n < 5; n++) cyc_w(1'b0, 32'h0, 1'b1);
    chk("ow_drop_model", w_drops, 2);
`ifdef TRACE_FIFO_MC_STATS_EN
    chk("ow_drop_cnt", w_drop, 16'd2);
    chk("ow_high_water", w_hw, 3'd4);
    chk("m_drop_cnt", m_drop, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
